mem_access_arbiter: RTL and testbench

- Sequences all traffic to the single-port 8 KiB x 8-bit command/data memory (13-bit address).
- Arbitrates between two requesters: the instruction-fetch unit and the data (load/store) unit of the multi-cycle CPU.
- Drives the memory's address, write-data and read/write strobes, waits a fixed access latency, then returns read data and a one-cycle acknowledge.
- Sits between the CPU control/datapath and the memory instance.

---
 rtl/mem_access_arbiter_pkg.sv | 19 +
 rtl/mem_access_arbiter_if.sv | 35 +++
 rtl/mem_access_arbiter_rr_pick2.sv | 43 ++++
 rtl/mem_access_arbiter.sv | 117 +++++++++++
 tb/tb_mem_access_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and default widths for the memory access arbiter.
// Imported by the interface, the picker and the top level.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    typedef enum logic {
        ReqIf,
        ReqD
    } req_id_e;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of requester handshakes and memory-side signals around the arbiter.
// slave = arbiter side, master = CPU requesters plus memory.
interface mem_arb_if #(
    parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = mem_arb_pkg::DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_writer;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack,
        output mem_address, mem_write_data, mem_read, mem_writer
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack,
        input  mem_address, mem_write_data, mem_read, mem_writer
    );

endinterface

// File: rtl/mem_access_arbiter_rr_pick2.sv
// Two-input picker: round-robin or data-first on conflict.
// last_grant moves only on a resolved conflict so lone grants do not skew fairness.
module rr_pick2
    import mem_arb_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_req_if,
    input  logic    i_req_d,
    input  logic    i_update,
    output logic    o_valid,
    output req_id_e o_grant
);

    req_id_e r_last_grant;
    logic    w_conflict;

    always_comb begin
        w_conflict = i_req_if && i_req_d;
        o_valid    = i_req_if || i_req_d;
        o_grant    = ReqIf;
        if (w_conflict) begin
            if (FIXED_PRIO != 0) begin
                o_grant = ReqD;
            end else begin
                o_grant = (r_last_grant == ReqD) ? ReqIf : ReqD;
            end
        end else if (i_req_d) begin
            o_grant = ReqD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= ReqD;
        end else if (i_update && w_conflict && (FIXED_PRIO == 0)) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Sequences fetch and load/store traffic onto a single-port memory with a fixed
// access latency; one access in flight at a time, one-cycle ack per access.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned FIXED_PRIO = 0
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    req_id_e           r_id, w_id_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_we, w_we_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;

    logic    w_valid;
    req_id_e w_grant;
    logic    w_idle, w_access, w_resp;
    logic    w_if_ack, w_d_ack;

    rr_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .i_req_if (bus.if_req),
        .i_req_d  (bus.d_req),
        .i_update (w_idle),
        .o_valid  (w_valid),
        .o_grant  (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_id    <= ReqIf;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_id    <= w_id_nxt;
            r_addr  <= w_addr_nxt;
            r_we    <= w_we_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_id_nxt    = r_id;
        w_addr_nxt  = r_addr;
        w_we_nxt    = r_we;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        unique case (r_state)
            StIdle: begin
                if (w_valid) begin
                    w_id_nxt    = w_grant;
                    w_addr_nxt  = (w_grant == ReqD) ? bus.d_addr : bus.if_addr;
                    w_we_nxt    = (w_grant == ReqD) && bus.d_we;
                    w_wdata_nxt = (w_grant == ReqD) ? bus.d_wdata : '0;
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = StAccess;
                end
            end
            StAccess: begin
                if (r_cnt == 4'd0) begin
                    w_rdata_nxt = r_we ? '0 : bus.mem_rdata;
                    w_state_nxt = StResp;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            StResp: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_comb begin
        w_idle   = (r_state == StIdle);
        w_access = (r_state == StAccess);
        w_resp   = (r_state == StResp);
        w_if_ack = w_resp && (r_id == ReqIf);
        w_d_ack  = w_resp && (r_id == ReqD);
    end

    // Write data is forced to 0 outside write strobes: the memory treats nonzero data as a write.
    assign bus.mem_address    = r_addr;
    assign bus.mem_read       = w_access && !r_we;
    assign bus.mem_writer     = w_access && r_we;
    assign bus.mem_write_data = (w_access && r_we) ? r_wdata : '0;
    assign bus.if_ack         = w_if_ack;
    assign bus.d_ack          = w_d_ack;
    assign bus.if_rdata       = w_if_ack ? r_rdata : '0;
    assign bus.d_rdata        = w_d_ack ? r_rdata : '0;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: three instances cover round-robin, fixed
// priority and single-cycle latency; memory returns address[7:0] ^ 0xE6.
module tb_mem_access_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [2:0]  if_req_v, d_req_v, d_we_v;
    logic [12:0] if_addr_v [3];
    logic [12:0] d_addr_v  [3];
    logic [7:0]  d_wdata_v [3];

    logic [2:0]  rd_o, wr_o, ifack_o, dack_o;
    logic [12:0] addr_o  [3];
    logic [7:0]  wdata_o [3];
    logic [7:0]  ifrd_o  [3];
    logic [7:0]  drd_o   [3];

    // 0: MEM_LAT=2 round-robin, 1: MEM_LAT=2 fixed priority, 2: MEM_LAT=1 round-robin
    for (genvar k = 0; k < 3; k++) begin : g_dut
        mem_arb_if #(.ADDR_W(13), .DATA_W(8)) bus ();

        assign bus.if_req    = if_req_v[k];
        assign bus.if_addr   = if_addr_v[k];
        assign bus.d_req     = d_req_v[k];
        assign bus.d_we      = d_we_v[k];
        assign bus.d_addr    = d_addr_v[k];
        assign bus.d_wdata   = d_wdata_v[k];
        assign bus.mem_rdata = bus.mem_address[7:0] ^ 8'hE6;

        assign rd_o[k]    = bus.mem_read;
        assign wr_o[k]    = bus.mem_writer;
        assign ifack_o[k] = bus.if_ack;
        assign dack_o[k]  = bus.d_ack;
        assign addr_o[k]  = bus.mem_address;
        assign wdata_o[k] = bus.mem_write_data;
        assign ifrd_o[k]  = bus.if_rdata;
        assign drd_o[k]   = bus.d_rdata;

        mem_access_arbiter #(
            .ADDR_W     (13),
            .DATA_W     (8),
            .MEM_LAT    ((k == 2) ? 1 : 2),
            .FIXED_PRIO ((k == 1) ? 1 : 0)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({addr_o[k], wdata_o[k], rd_o[k], wr_o[k], ifack_o[k], dack_o[k],
                 ifrd_o[k], drd_o[k]} !== 44'h0) begin
                errors++;
                $display("FAIL reset_outputs dut=%0d got addr=%h wd=%h rd=%b wr=%b ia=%b da=%b exp all 0",
                         k, addr_o[k], wdata_o[k], rd_o[k], wr_o[k], ifack_o[k], dack_o[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch_read();
        logic       e_rd, e_ack;
        logic [7:0] e_rdata;
        if_req_v[0]  = 1'b1;
        if_addr_v[0] = 13'h0000;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            e_rd    = (c <= 2);
            e_ack   = (c == 3);
            e_rdata = e_ack ? 8'hE6 : 8'h00;
            checks += 4;
            if (rd_o[0] !== e_rd) begin
                errors++;
                $display("FAIL fetch_read_strobe c=%0d got %b exp %b", c, rd_o[0], e_rd);
            end
            if (ifack_o[0] !== e_ack || dack_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL fetch_ack c=%0d got if=%b d=%b exp if=%b d=0",
                         c, ifack_o[0], dack_o[0], e_ack);
            end
            if (ifrd_o[0] !== e_rdata) begin
                errors++;
                $display("FAIL fetch_rdata c=%0d got %h exp %h", c, ifrd_o[0], e_rdata);
            end
            if (wr_o[0] !== 1'b0 || wdata_o[0] !== 8'h00) begin
                errors++;
                $display("FAIL fetch_no_write c=%0d got wr=%b wd=%h exp 0", c, wr_o[0], wdata_o[0]);
            end
            if (e_rd) begin
                checks++;
                if (addr_o[0] !== 13'h0000) begin
                    errors++;
                    $display("FAIL fetch_addr c=%0d got %h exp 0000", c, addr_o[0]);
                end
            end
            if (c == 3) if_req_v[0] = 1'b0;
        end
    endtask

    task automatic test_data_write();
        logic       e_wr, e_ack;
        logic [7:0] e_wd;
        d_req_v[0]   = 1'b1;
        d_we_v[0]    = 1'b1;
        d_addr_v[0]  = 13'h1FFF;
        d_wdata_v[0] = 8'h5A;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            e_wr  = (c <= 2);
            e_wd  = e_wr ? 8'h5A : 8'h00;
            e_ack = (c == 3);
            checks += 4;
            if (wr_o[0] !== e_wr || rd_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL write_strobe c=%0d got wr=%b rd=%b exp wr=%b rd=0",
                         c, wr_o[0], rd_o[0], e_wr);
            end
            if (wdata_o[0] !== e_wd) begin
                errors++;
                $display("FAIL write_data c=%0d got %h exp %h", c, wdata_o[0], e_wd);
            end
            if (dack_o[0] !== e_ack || ifack_o[0] !== 1'b0 || drd_o[0] !== 8'h00) begin
                errors++;
                $display("FAIL write_ack c=%0d got d=%b if=%b drd=%h exp d=%b if=0 drd=00",
                         c, dack_o[0], ifack_o[0], drd_o[0], e_ack);
            end
            // address is expected to persist past the access
            if (addr_o[0] !== 13'h1FFF) begin
                errors++;
                $display("FAIL write_addr c=%0d got %h exp 1fff", c, addr_o[0]);
            end
            if (c == 3) begin
                d_req_v[0] = 1'b0;
                d_we_v[0]  = 1'b0;
            end
        end
    endtask

    task automatic test_rr_conflict();
        int          j;
        logic        e_if, e_d;
        logic [12:0] e_addr;
        logic [7:0]  e_rd;
        if_req_v[0]  = 1'b1;
        if_addr_v[0] = 13'h0010;
        d_req_v[0]   = 1'b1;
        d_we_v[0]    = 1'b0;
        d_addr_v[0]  = 13'h0020;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            j      = c / 4;
            e_if   = (c % 4 == 3) && (j % 2 == 0);
            e_d    = (c % 4 == 3) && (j % 2 == 1);
            e_addr = (j % 2 == 0) ? 13'h0010 : 13'h0020;
            e_rd   = e_addr[7:0] ^ 8'hE6;
            checks += 2;
            if (ifack_o[0] !== e_if || dack_o[0] !== e_d) begin
                errors++;
                $display("FAIL rr_order c=%0d got if=%b d=%b exp if=%b d=%b",
                         c, ifack_o[0], dack_o[0], e_if, e_d);
            end
            if (ifrd_o[0] !== (e_if ? e_rd : 8'h00) || drd_o[0] !== (e_d ? e_rd : 8'h00)) begin
                errors++;
                $display("FAIL rr_rdata c=%0d got if=%h d=%h exp %h", c, ifrd_o[0], drd_o[0], e_rd);
            end
            if (c % 4 == 1 || c % 4 == 2) begin
                checks++;
                if (addr_o[0] !== e_addr || rd_o[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_addr c=%0d got %h rd=%b exp %h rd=1",
                             c, addr_o[0], rd_o[0], e_addr);
                end
            end
            if (c == 15) begin
                if_req_v[0] = 1'b0;
                d_req_v[0]  = 1'b0;
            end
        end
    endtask

    task automatic test_fixed_prio();
        logic e_if, e_d;
        if_req_v[1]  = 1'b1;
        if_addr_v[1] = 13'h0010;
        d_req_v[1]   = 1'b1;
        d_we_v[1]    = 1'b0;
        d_addr_v[1]  = 13'h0020;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            e_d  = (c % 4 == 3) && (c <= 11);
            e_if = (c == 15);
            checks += 2;
            if (ifack_o[1] !== e_if || dack_o[1] !== e_d) begin
                errors++;
                $display("FAIL fixed_prio_ack c=%0d got if=%b d=%b exp if=%b d=%b",
                         c, ifack_o[1], dack_o[1], e_if, e_d);
            end
            if (drd_o[1] !== (e_d ? 8'hC6 : 8'h00) || ifrd_o[1] !== (e_if ? 8'hF6 : 8'h00)) begin
                errors++;
                $display("FAIL fixed_prio_rdata c=%0d got if=%h d=%h", c, ifrd_o[1], drd_o[1]);
            end
            if (c == 11) d_req_v[1] = 1'b0;
            if (c == 15) if_req_v[1] = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic       e_rd, e_if;
        logic [7:0] e_rdata;
        if_req_v[0]  = 1'b1;
        if_addr_v[0] = 13'h0005;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            e_rd    = (c == 1) || (c == 2) || (c == 4) || (c == 5) || (c == 8) || (c == 9);
            e_if    = (c == 6) || (c == 10);
            e_rdata = e_if ? 8'hE3 : 8'h00;
            checks += 3;
            if (rd_o[0] !== e_rd || wr_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_strobe c=%0d got rd=%b wr=%b exp rd=%b wr=0",
                         c, rd_o[0], wr_o[0], e_rd);
            end
            if (ifack_o[0] !== e_if || dack_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_ack c=%0d got if=%b d=%b exp if=%b d=0",
                         c, ifack_o[0], dack_o[0], e_if);
            end
            if (ifrd_o[0] !== e_rdata) begin
                errors++;
                $display("FAIL rst_mid_rdata c=%0d got %h exp %h", c, ifrd_o[0], e_rdata);
            end
            if (c == 3) begin
                checks++;
                if (addr_o[0] !== 13'h0000) begin
                    errors++;
                    $display("FAIL rst_mid_addr c=%0d got %h exp 0000", c, addr_o[0]);
                end
            end
            if (c == 2) rst = 1'b1;
            if (c == 3) rst = 1'b0;
            if (c == 6) begin
                d_req_v[0]  = 1'b1;
                d_we_v[0]   = 1'b0;
                d_addr_v[0] = 13'h0020;
            end
            if (c == 10) begin
                if_req_v[0] = 1'b0;
                d_req_v[0]  = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        int          n;
        logic        e_rd, e_ack;
        logic [12:0] e_addr;
        if_req_v[2]  = 1'b1;
        if_addr_v[2] = 13'h0100;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            n      = (c - 1) / 3;
            e_rd   = (c % 3 == 1);
            e_ack  = (c % 3 == 2);
            e_addr = 13'h0100 + 13'(n);
            checks += 2;
            if (rd_o[2] !== e_rd || ifack_o[2] !== e_ack) begin
                errors++;
                $display("FAIL b2b_timing c=%0d got rd=%b ack=%b exp rd=%b ack=%b",
                         c, rd_o[2], ifack_o[2], e_rd, e_ack);
            end
            if (ifrd_o[2] !== (e_ack ? (e_addr[7:0] ^ 8'hE6) : 8'h00)) begin
                errors++;
                $display("FAIL b2b_rdata c=%0d got %h exp %h", c, ifrd_o[2],
                         e_ack ? (e_addr[7:0] ^ 8'hE6) : 8'h00);
            end
            if (e_rd) begin
                checks++;
                if (addr_o[2] !== e_addr) begin
                    errors++;
                    $display("FAIL b2b_addr c=%0d got %h exp %h", c, addr_o[2], e_addr);
                end
            end
            if (e_ack) begin
                if_addr_v[2] = 13'h0100 + 13'(n + 1);
                if (n == 2) if_req_v[2] = 1'b0;
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        if_req_v = '0;
        d_req_v  = '0;
        d_we_v   = '0;
        for (int k = 0; k < 3; k++) begin
            if_addr_v[k] = '0;
            d_addr_v[k]  = '0;
            d_wdata_v[k] = '0;
        end
        test_reset();
        test_fetch_read();
        test_data_write();
        test_rr_conflict();
        test_fixed_prio();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
